// File: rtl/downsize_arbiter_if.sv
// rtl/downsize_arbiter_if.sv - requester and narrow-beat handshake bundle for downsize_arbiter
interface downsize_arbiter_if #(
  parameter int N_REQ     = 4,
  parameter int IN_BYTES  = 16,
  parameter int OUT_BYTES = 4,
  parameter int SRC_W     = $clog2(N_REQ)
);
  logic [N_REQ-1:0]            req_valid;
  logic [N_REQ*IN_BYTES*8-1:0] req_data;
  logic [N_REQ-1:0]            req_ready;
  logic                        out_valid;
  logic [OUT_BYTES*8-1:0]      out_data;
  logic                        out_last;
  logic [SRC_W-1:0]            out_src;
  logic                        out_ready;

  modport master (
    output req_valid, req_data, out_ready,
    input  req_ready, out_valid, out_data, out_last, out_src
  );

  modport slave (
    input  req_valid, req_data, out_ready,
    output req_ready, out_valid, out_data, out_last, out_src
  );
endinterface

// File: rtl/downsize_arbiter.sv
// rtl/downsize_arbiter.sv - round-robin arbiter serializing wide requester words into narrow beats
module downsize_arbiter #(
  parameter int N_REQ     = 4,
  parameter int IN_BYTES  = 16,
  parameter int OUT_BYTES = 4,
  parameter int SRC_W     = $clog2(N_REQ)
) (
  input  logic              clk,
  input  logic              rst,
  downsize_arbiter_if.slave bus,
  output logic              busy
);
  localparam int IW     = IN_BYTES * 8;
  localparam int OW     = OUT_BYTES * 8;
  localparam int RATIO  = IN_BYTES / OUT_BYTES;
  localparam int BEAT_W = $clog2(RATIO);

  typedef enum logic {IDLE, SEND} state_t;

  state_t                     state_q, state_d;
  logic [N_REQ-1:0][IW-1:0]   req_words;
  logic [RATIO-1:0][OW-1:0]   word;
  logic [BEAT_W-1:0]          beat;
  logic [SRC_W-1:0]           ptr;
  logic [SRC_W-1:0]           src;
  logic [SRC_W-1:0]           grant;
  logic                       found;
  logic                       last_beat;
  logic                       accept;
  int                         idx;

  assign req_words = bus.req_data;
  assign last_beat = (beat == BEAT_W'(RATIO - 1));
  assign accept    = (state_q == IDLE) && found && !rst;

  // Rotating priority: search starts at ptr and wraps past N_REQ-1.
  always_comb begin
    grant = '0;
    found = 1'b0;
    idx   = 0;
    for (int k = 0; k < N_REQ; k++) begin
      idx = int'(ptr) + k;
      if (idx >= N_REQ) idx = idx - N_REQ;
      if (!found && bus.req_valid[idx[SRC_W-1:0]]) begin
        found = 1'b1;
        grant = idx[SRC_W-1:0];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d       = state_q;
    bus.req_ready = '0;
    bus.out_valid = 1'b0;
    bus.out_data  = '0;
    bus.out_last  = 1'b0;
    bus.out_src   = rst ? '0 : src;
    busy          = 1'b0;
    case (state_q)
      IDLE: begin
        if (accept) begin
          bus.req_ready[grant] = 1'b1;
          state_d              = SEND;
        end
      end
      SEND: begin
        if (!rst) begin
          bus.out_valid = 1'b1;
          bus.out_data  = word[beat];
          bus.out_last  = last_beat;
          busy          = 1'b1;
        end
        if (bus.out_ready && last_beat) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      word <= '0;
      beat <= '0;
      ptr  <= '0;
      src  <= '0;
    end else if (accept) begin
      word <= req_words[grant];
      src  <= grant;
      ptr  <= (grant == SRC_W'(N_REQ - 1)) ? '0 : grant + 1'b1;
      beat <= '0;
    end else if (state_q == SEND && bus.out_ready) begin
      beat <= last_beat ? '0 : beat + 1'b1;
    end
  end
endmodule

// File: tb/tb_downsize_arbiter.sv
// tb/tb_downsize_arbiter.sv - scoreboard bench for downsize_arbiter against a queue-based reference model
module tb_downsize_arbiter;
  localparam int N     = 4;
  localparam int IB    = 16;
  localparam int OB    = 4;
  localparam int SW    = 2;
  localparam int IW    = IB * 8;
  localparam int OW    = OB * 8;
  localparam int RATIO = IB / OB;

  typedef struct {
    logic [OW-1:0] data;
    logic          last;
    logic [SW-1:0] src;
  } beat_t;

  logic clk = 1'b0;
  logic rst;
  logic busy;

  downsize_arbiter_if #(.N_REQ(N), .IN_BYTES(IB), .OUT_BYTES(OB), .SRC_W(SW)) bus ();

  downsize_arbiter #(.N_REQ(N), .IN_BYTES(IB), .OUT_BYTES(OB), .SRC_W(SW)) dut (
    .clk  (clk),
    .rst  (rst),
    .bus  (bus),
    .busy (busy)
  );

  always #5 clk = ~clk;

  int    checks = 0;
  int    errors = 0;
  beat_t sb[$];
  int    m_ptr = 0;
  int    m_remaining = 0;
  int    lasts = 0;
  logic [N-1:0] acc = '0;

  bit auto = 0;
  int p_offer = 0, p_ready = 100, p_wd = 0;
  bit p_rst = 0;

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Predictor: decides the grant from the spec's rotating-priority rule and queues the word's beats.
  always @(negedge clk) begin
    logic [N-1:0] exp_rdy;
    int g;
    acc = bus.req_valid & bus.req_ready;
    if (rst) begin
      check("rst_out_valid", bus.out_valid, 0);
      check("rst_out_data", bus.out_data, 0);
      check("rst_out_last", bus.out_last, 0);
      check("rst_out_src", bus.out_src, 0);
      check("rst_busy", busy, 0);
      check("rst_req_ready", bus.req_ready, 0);
      sb.delete();
      m_ptr = 0;
      m_remaining = 0;
    end else if (m_remaining == 0) begin
      g = -1;
      for (int k = 0; k < N; k++)
        if (g < 0 && bus.req_valid[(m_ptr + k) % N]) g = (m_ptr + k) % N;
      exp_rdy = '0;
      if (g >= 0) exp_rdy[g] = 1'b1;
      check("idle_req_ready", bus.req_ready, exp_rdy);
      check("idle_out_valid", bus.out_valid, 0);
      check("idle_out_data", bus.out_data, 0);
      check("idle_busy", busy, 0);
      if (g >= 0) begin
        logic [IW-1:0] w;
        w = bus.req_data[g*IW +: IW];
        for (int b = 0; b < RATIO; b++) begin
          beat_t e;
          e.data = w[b*OW +: OW];
          e.last = (b == RATIO - 1);
          e.src  = SW'(g);
          sb.push_back(e);
        end
        m_ptr = (g + 1) % N;
        m_remaining = RATIO;
      end
    end else begin
      check("send_req_ready", bus.req_ready, 0);
      check("send_out_valid", bus.out_valid, 1);
      check("send_busy", busy, 1);
      if (bus.out_ready) m_remaining--;
    end
  end

  // Monitor: compares every presented beat with the scoreboard head; pops only on handshake.
  always @(negedge clk) begin
    if (!rst && bus.out_valid) begin
      if (sb.size() == 0) begin
        check("unexpected_beat", 1, 0);
      end else begin
        check("beat_data", bus.out_data, sb[0].data);
        check("beat_last", bus.out_last, sb[0].last);
        check("beat_src", bus.out_src, sb[0].src);
        if (bus.out_ready) begin
          if (bus.out_last) lasts++;
          void'(sb.pop_front());
        end
      end
    end
  end

  initial begin
    forever begin
      @(posedge clk);
      #1;
      if (auto) begin
        for (int i = 0; i < N; i++) begin
          if (bus.req_valid[i] && acc[i]) bus.req_valid[i] = 1'b0;
          else if (bus.req_valid[i] && $urandom_range(0, 99) < p_wd) bus.req_valid[i] = 1'b0;
          else if (!bus.req_valid[i]) continue;
        end
        for (int i = 0; i < N; i++) begin
          if (!bus.req_valid[i] && $urandom_range(0, 99) < p_offer) begin
            bus.req_valid[i] = 1'b1;
            bus.req_data[i*IW +: IW] = {$urandom, $urandom, $urandom, $urandom};
          end
        end
        bus.out_ready = ($urandom_range(0, 99) < p_ready);
        rst = p_rst && ($urandom_range(0, 149) == 0);
      end
    end
  end

  task automatic wait_accept(input int i, input string name);
    bit got = 0;
    for (int c = 0; c < 20 && !got; c++) begin
      @(negedge clk);
      got = bus.req_valid[i] && bus.req_ready[i];
    end
    check(name, got, 1);
    @(posedge clk);
    #1;
  endtask

  initial begin
    int l0;
    rst = 1'b1;
    bus.req_valid = '0;
    bus.req_data = '0;
    bus.out_ready = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;

    // Single source on requester 2 with byte-index pattern.
    bus.out_ready = 1'b1;
    bus.req_data[2*IW +: IW] = 128'h0F0E0D0C0B0A09080706050403020100;
    bus.req_valid = 4'b0100;
    wait_accept(2, "single_grant");
    bus.req_valid = '0;
    repeat (8) @(posedge clk);
    #1;

    // Reset in mid-word; pending requester 3 must be granted afterwards.
    bus.req_data[0*IW +: IW] = {$urandom, $urandom, $urandom, $urandom};
    bus.req_data[3*IW +: IW] = {$urandom, $urandom, $urandom, $urandom};
    bus.req_valid = 4'b0001;
    wait_accept(0, "pre_reset_grant");
    bus.req_valid = 4'b1000;
    repeat (2) @(posedge clk);
    #1 rst = 1'b1;
    @(posedge clk);
    #1 rst = 1'b0;
    wait_accept(3, "post_reset_grant");
    bus.req_valid = '0;
    repeat (8) @(posedge clk);
    #1;

    // All requesters saturated: one word per RATIO+1 cycles.
    auto = 1; p_offer = 100; p_ready = 100; p_wd = 0; p_rst = 0;
    repeat (10) @(posedge clk);
    l0 = lasts;
    repeat (40) @(posedge clk);
    check("rr_throughput", 128'(lasts - l0), 8);

    // Random traffic with backpressure, withdrawals and reset pulses.
    p_offer = 30; p_ready = 70; p_wd = 10; p_rst = 1;
    repeat (3000) @(posedge clk);

    auto = 0;
    @(posedge clk);
    #1;
    rst = 1'b0;
    bus.req_valid = '0;
    bus.out_ready = 1'b1;
    for (int c = 0; c < 20 && busy; c++) @(posedge clk);
    @(negedge clk);
    check("drain_busy", busy, 0);
    check("drain_scoreboard", sb.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
